prbs4_checker: RTL and testbench

Downstream consumer of the team's 4-bit Fibonacci LFSR pattern generator. It receives the generator's word stream, self-synchronises to it, and declares lock. While locked it flags every mismatching word and keeps a saturating error count. It is used for link and loopback bring-up, with the generator on the transmit side and this checker on the receive side.

---
 rtl/prbs4_pkg.sv | 18 +
 rtl/prbs4_sat_counter.sv | 23 ++
 rtl/prbs4_checker.sv | 149 ++++++++++++++
 tb/tb_prbs4_checker.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/prbs4_pkg.sv
// Shared definitions for the 4-bit PRBS checker: pattern step function,
// FSM state type and the seed / illegal word constants.
package prbs4_pkg;

   typedef enum logic {
      HUNT   = 1'b0,
      LOCKED = 1'b1
   } state_t;

   localparam logic [3:0] PRBS_SEED = 4'b0001;
   localparam logic [3:0] PRBS_ZERO = 4'b0000;

   // Fibonacci step, taps 3 and 2, period 15
   function automatic logic [3:0] prbs4_next(input logic [3:0] w);
      return {w[2:0], w[3] ^ w[2]};
   endfunction

endpackage

// File: rtl/prbs4_sat_counter.sv
// Saturating up-counter; clr has priority over inc, holds at all-ones.
// Ports: clk, rst (async, active-high), clr, inc, count[W-1:0].
module prbs4_sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] count
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && (count != {W{1'b1}})) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/prbs4_checker.sv
// PRBS4 receive checker: self-synchronises to the generator stream, then
// flags and counts mismatching words while locked.
// Ports: clk, rst (async, active-high), clr (sync clear of error state),
//   in_valid, in_data[3:0], locked, err_pulse, err_count[ERR_W-1:0].
// Macro PRBS_CHK_ERR_CAPTURE_EN adds first_err_valid, first_err_rcv[3:0]
//   and first_err_exp[3:0], holding the first mismatch since reset/clr.
module prbs4_checker
   import prbs4_pkg::*;
#(
   parameter int LOCK_CNT   = 4,
   parameter int UNLOCK_CNT = 3,
   parameter int ERR_W      = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             in_valid,
   input  logic [3:0]       in_data,
   output logic             locked,
   output logic             err_pulse,
   output logic [ERR_W-1:0] err_count
`ifdef PRBS_CHK_ERR_CAPTURE_EN
   ,
   output logic             first_err_valid,
   output logic [3:0]       first_err_rcv,
   output logic [3:0]       first_err_exp
`endif
);

   localparam int GW = $clog2(LOCK_CNT + 1);
   localparam int BW = $clog2(UNLOCK_CNT + 1);

   state_t          state, state_d;
   logic [3:0]      prev, prev_d;
   logic [3:0]      exp_word, exp_d;
   logic            have_prev, have_prev_d;
   logic [GW-1:0]   good_run, good_run_d;
   logic [BW-1:0]   bad_run, bad_run_d;
   logic            err_d;
   logic            hunt_match;
   logic            lock_miss;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= HUNT;
         prev      <= PRBS_ZERO;
         exp_word  <= PRBS_SEED;
         have_prev <= 1'b0;
         good_run  <= '0;
         bad_run   <= '0;
         err_pulse <= 1'b0;
      end else begin
         state     <= state_d;
         prev      <= prev_d;
         exp_word  <= exp_d;
         have_prev <= have_prev_d;
         good_run  <= good_run_d;
         bad_run   <= bad_run_d;
         err_pulse <= err_d;
      end
   end

   always_comb begin
      state_d     = state;
      prev_d      = prev;
      exp_d       = exp_word;
      have_prev_d = have_prev;
      good_run_d  = good_run;
      bad_run_d   = bad_run;
      err_d       = 1'b0;
      hunt_match  = (in_data == prbs4_next(prev)) &&
                    (in_data != PRBS_ZERO);
      lock_miss   = (in_data != exp_word) ||
                    (in_data == PRBS_ZERO);
      if (in_valid) begin
         unique case (state)
            HUNT: begin
               prev_d = in_data;
               if (!have_prev) begin
                  have_prev_d = 1'b1;
                  good_run_d  = '0;
               end else if (hunt_match) begin
                  if (good_run == GW'(LOCK_CNT - 1)) begin
                     state_d    = LOCKED;
                     exp_d      = prbs4_next(in_data);
                     good_run_d = '0;
                     bad_run_d  = '0;
                  end else begin
                     good_run_d = good_run + 1'b1;
                  end
               end else begin
                  good_run_d = '0;
               end
            end
            LOCKED: begin
               // free-running reference: one bad word cannot resync it
               exp_d = prbs4_next(exp_word);
               if (lock_miss) begin
                  err_d = 1'b1;
                  if (bad_run == BW'(UNLOCK_CNT - 1)) begin
                     state_d     = HUNT;
                     have_prev_d = 1'b0;
                     good_run_d  = '0;
                     bad_run_d   = '0;
                  end else begin
                     bad_run_d = bad_run + 1'b1;
                  end
               end else begin
                  bad_run_d = '0;
               end
            end
            default: begin
               state_d = HUNT;
            end
         endcase
      end
   end

   assign locked = (state == LOCKED);

   prbs4_sat_counter #(
      .W (ERR_W)
   ) u_err_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr   (clr),
      .inc   (err_d),
      .count (err_count)
   );

`ifdef PRBS_CHK_ERR_CAPTURE_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         first_err_valid <= 1'b0;
         first_err_rcv   <= PRBS_ZERO;
         first_err_exp   <= PRBS_ZERO;
      end else if (clr) begin
         first_err_valid <= 1'b0;
         first_err_rcv   <= PRBS_ZERO;
         first_err_exp   <= PRBS_ZERO;
      end else if (err_d && !first_err_valid) begin
         first_err_valid <= 1'b1;
         first_err_rcv   <= in_data;
         first_err_exp   <= exp_word;
      end
   end
`endif

endmodule

// File: tb/tb_prbs4_checker.sv
// Directed bench for prbs4_checker: lock, single error, loss of lock,
// valid gaps, reset mid-lock, and saturation/clr on a 2-bit counter copy.
module tb_prbs4_checker;

   logic        clk = 1'b0;
   logic        rst;
   logic        clr;
   logic        in_valid;
   logic [3:0]  in_data;
   logic        locked, err_pulse;
   logic [15:0] err_count;
   logic        locked_s, err_pulse_s;
   logic [1:0]  err_count_s;
`ifdef PRBS_CHK_ERR_CAPTURE_EN
   logic        fev, fev_s;
   logic [3:0]  frcv, fexp, frcv_s, fexp_s;
   logic [3:0]  cap_rcv, cap_exp;
`endif

   int checks = 0;
   int errs   = 0;
   int idx    = 0;
   int gap;
   logic [3:0] seq [15] = '{
      4'b0001, 4'b0010, 4'b0100, 4'b1001, 4'b0011,
      4'b0110, 4'b1101, 4'b1010, 4'b0101, 4'b1011,
      4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000
   };

   always #5 clk = ~clk;

   prbs4_checker dut (
      .clk       (clk),
      .rst       (rst),
      .clr       (clr),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .locked    (locked),
      .err_pulse (err_pulse),
      .err_count (err_count)
`ifdef PRBS_CHK_ERR_CAPTURE_EN
      ,
      .first_err_valid (fev),
      .first_err_rcv   (frcv),
      .first_err_exp   (fexp)
`endif
   );

   prbs4_checker #(
      .ERR_W (2)
   ) dut_s (
      .clk       (clk),
      .rst       (rst),
      .clr       (clr),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .locked    (locked_s),
      .err_pulse (err_pulse_s),
      .err_count (err_count_s)
`ifdef PRBS_CHK_ERR_CAPTURE_EN
      ,
      .first_err_valid (fev_s),
      .first_err_rcv   (frcv_s),
      .first_err_exp   (fexp_s)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] want);
      checks++;
      assert (got === want) else begin
         errs++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, want);
      end
   endtask

   task automatic send(input logic [3:0] w);
      in_valid = 1'b1;
      in_data  = w;
      @(posedge clk);
      #1;
   endtask

   task automatic clean();
      send(seq[idx]);
      idx = (idx + 1) % 15;
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      rst      = 1'b1;
      clr      = 1'b0;
      in_valid = 1'b0;
      in_data  = 4'b0000;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_locked", locked, 0);
      chk("rst_pulse", err_pulse, 0);
      chk("rst_count", err_count, 0);
      chk("rst_count_s", err_count_s, 0);
      rst = 1'b0;

      for (int i = 0; i < 4; i++) clean();
      chk("lock_early", locked, 0);
      clean();
      chk("lock_5th", locked, 1);
      chk("lock_5th_s", locked_s, 1);
      for (int i = 0; i < 30; i++) begin
         clean();
         chk("clean_pulse", err_pulse, 0);
      end
      chk("clean_count", err_count, 0);
      chk("clean_locked", locked, 1);

      while (seq[idx] != 4'b0110) clean();
      send(4'b0111);
      idx = (idx + 1) % 15;
      chk("single_pulse", err_pulse, 1);
      chk("single_count", err_count, 1);
      chk("single_locked", locked, 1);
      chk("next_is_1101", seq[idx], 4'b1101);
      clean();
      chk("after_single_pulse", err_pulse, 0);
      chk("after_single_count", err_count, 1);

      in_valid = 1'b0;
      clr = 1'b1;
      @(posedge clk);
      #1;
      clr = 1'b0;
      chk("clr_count", err_count, 0);
      chk("clr_locked", locked, 1);

      for (int k = 0; k < 3; k++) begin
         send(4'b0000);
         idx = (idx + 1) % 15;
         chk("zero_pulse", err_pulse, 1);
         chk("zero_locked", locked, (k < 2) ? 1 : 0);
      end
      chk("unlock_count", err_count, 3);
      chk("unlock_count_s", err_count_s, 3);
      clean();
      chk("relock_seed_pulse", err_pulse, 0);
      for (int i = 0; i < 3; i++) clean();
      chk("relock_early", locked, 0);
      clean();
      chk("relock", locked, 1);

      #2;
      rst = 1'b1;
      #1;
      chk("async_locked", locked, 0);
      chk("async_count", err_count, 0);
      chk("async_count_s", err_count_s, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      for (int i = 0; i < 5; i++) begin
         clean();
         chk("gap_lock", locked, (i == 4) ? 1 : 0);
         gap = $urandom_range(1, 3);
         idle(gap);
         chk("gap_frozen", locked, (i == 4) ? 1 : 0);
         chk("gap_pulse", err_pulse, 0);
      end
      for (int i = 0; i < 20; i++) begin
         clean();
         chk("gap_clean_pulse", err_pulse, 0);
         gap = $urandom_range(0, 2);
         idle(gap);
      end
      chk("gap_count", err_count, 0);
      chk("gap_locked", locked, 1);
`ifdef PRBS_CHK_ERR_CAPTURE_EN
      chk("cap_none", fev, 0);
`endif

      for (int e = 0; e < 5; e++) begin
`ifdef PRBS_CHK_ERR_CAPTURE_EN
         if (e == 0) begin
            cap_rcv = seq[idx] ^ 4'b0100;
            cap_exp = seq[idx];
         end
`endif
         send(seq[idx] ^ 4'b0100);
         idx = (idx + 1) % 15;
         chk("iso_pulse", err_pulse, 1);
         clean();
         clean();
         chk("iso_clean_pulse", err_pulse, 0);
      end
      chk("iso_count", err_count, 5);
      chk("sat_count_s", err_count_s, 3);
      chk("iso_locked", locked, 1);
`ifdef PRBS_CHK_ERR_CAPTURE_EN
      chk("cap_valid", fev, 1);
      chk("cap_rcv", frcv, cap_rcv);
      chk("cap_exp", fexp, cap_exp);
`endif

      clr = 1'b1;
      send(seq[idx] ^ 4'b0100);
      idx = (idx + 1) % 15;
      clr = 1'b0;
      chk("clr_err_pulse", err_pulse, 1);
      chk("clr_err_pulse_s", err_pulse_s, 1);
      chk("clr_err_count", err_count, 0);
      chk("clr_err_count_s", err_count_s, 0);
      chk("clr_err_locked", locked, 1);
`ifdef PRBS_CHK_ERR_CAPTURE_EN
      chk("cap_cleared", fev, 0);
`endif
      clean();
      chk("final_pulse", err_pulse, 0);
      chk("final_count", err_count, 0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
